// File: rtl/alarm_trigger.sv
// Alarm trigger: watches the running MM:SS time against the latched alarm digits and
// sequences ring / snooze / dismiss, driving registered ringing, buzz and fired outputs.
module alarm_trigger #(
    parameter int unsigned RING_TICKS   = 40,
    parameter int unsigned SNOOZE_TICKS = 20,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic       clk4,
    input  logic       reset,
    input  logic       arm,
    input  logic       setting_active,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic [3:0] cur_sec_tens,
    input  logic [3:0] cur_sec_units,
    input  logic [3:0] alm_min_tens,
    input  logic [3:0] alm_min_units,
    input  logic [3:0] alm_sec_tens,
    input  logic [3:0] alm_sec_units,
    input  logic       dismiss,
    input  logic       snooze,
    output logic       ringing,
    output logic       buzz,
    output logic       fired,
    output logic [2:0] snooze_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } state_t;

    localparam logic [15:0] RING_LAST = 16'(RING_TICKS - 1);
    localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_TICKS - 1);
    localparam logic [2:0]  SNZ_MAX   = 3'(MAX_SNOOZE);

    state_t      state_q, state_d;
    logic [15:0] ring_cnt_q, ring_cnt_d;
    logic [15:0] snz_cnt_q, snz_cnt_d;
    logic [2:0]  snooze_count_d;
    logic        buzz_d, fired_d, ringing_d;
    logic        match, match_prev, trigger;

    assign match = (cur_min_tens  == alm_min_tens)  && (cur_min_units == alm_min_units) &&
                   (cur_sec_tens  == alm_sec_tens)  && (cur_sec_units == alm_sec_units);

    // Only a fresh match edge fires, so a match that was already present when
    // setting mode ends stays silent.
    assign trigger = arm && !setting_active && match && !match_prev;

    assign state = state_q;

    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snz_cnt_d      = snz_cnt_q;
        snooze_count_d = snooze_count;
        buzz_d         = 1'b0;
        fired_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d        = RINGING;
                    ring_cnt_d     = '0;
                    buzz_d         = 1'b1;
                    fired_d        = 1'b1;
                    snooze_count_d = '0;
                end
            end
            RINGING: begin
                if (!arm || dismiss) begin
                    state_d        = IDLE;
                    snooze_count_d = '0;
                end else if (snooze && (snooze_count < SNZ_MAX)) begin
                    state_d        = SNOOZE;
                    snz_cnt_d      = SNZ_LOAD;
                    snooze_count_d = snooze_count + 3'd1;
                end else if (ring_cnt_q == RING_LAST) begin
                    state_d        = IDLE;
                    snooze_count_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 16'd1;
                    buzz_d     = !buzz;
                end
            end
            SNOOZE: begin
                if (!arm || dismiss) begin
                    state_d        = IDLE;
                    snooze_count_d = '0;
                end else if (snz_cnt_q == 16'd0) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    buzz_d     = 1'b1;
                end else begin
                    snz_cnt_d = snz_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d        = IDLE;
                snooze_count_d = '0;
            end
        endcase
        ringing_d = (state_d == RINGING);
    end

    always_ff @(posedge clk4) begin
        if (reset) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            snooze_count <= '0;
            buzz         <= 1'b0;
            fired        <= 1'b0;
            ringing      <= 1'b0;
            match_prev   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            snooze_count <= snooze_count_d;
            buzz         <= buzz_d;
            fired        <= fired_d;
            ringing      <= ringing_d;
            match_prev   <= match;
        end
    end

endmodule
